sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external async SRAM between a CPU port (read/write)
// and a video fetch port (read-only). One grant at a time; each access is a
// single strobe cycle, two wait cycles and a one-cycle ack.
// Optional build macro SRAM_ARB_RR_EN: round-robin arbitration between the two
// ports when both request in IDLE. Without it, video always wins a tie.
module sram_arbiter #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iCpuReq,
    input  logic              iCpuWr,
    input  logic [ADDR_W-1:0] iCpuAddr,
    input  logic [DATA_W-1:0] iCpuData,
    output logic [DATA_W-1:0] oCpuData,
    output logic              oCpuAck,
    input  logic              iVidReq,
    input  logic [ADDR_W-1:0] iVidAddr,
    output logic [DATA_W-1:0] oVidData,
    output logic              oVidAck,
    output logic              oSramRd,
    output logic              oSramWr,
    output logic [ADDR_W-1:0] oSramAddr,
    output logic [DATA_W-1:0] oSramDout,
    input  logic [DATA_W-1:0] iSramDin
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STROBE = 3'd1,
        S_WAIT1  = 3'd2,
        S_WAIT2  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_VID = 1'b1;

    state_t              state_q,     state_d;
    logic                owner_q,     owner_d;
    logic                wr_q,        wr_d;
    logic                sram_rd_q,   sram_rd_d;
    logic                sram_wr_q,   sram_wr_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]   sram_dout_q, sram_dout_d;
    logic [DATA_W-1:0]   cpu_data_q,  cpu_data_d;
    logic [DATA_W-1:0]   vid_data_q,  vid_data_d;
    logic                cpu_ack_q,   cpu_ack_d;
    logic                vid_ack_q,   vid_ack_d;
`ifdef SRAM_ARB_RR_EN
    logic                last_q,      last_d;
`endif

    logic                grant_c;
    logic                grant_vid_c;

    // Arbitration: decide whether a grant happens this cycle and who wins it
    always_comb begin
        grant_c = (state_q == S_IDLE) && (iCpuReq || iVidReq);
`ifdef SRAM_ARB_RR_EN
        if (iCpuReq && iVidReq) begin
            grant_vid_c = (last_q == OWN_CPU);
        end else begin
            grant_vid_c = iVidReq;
        end
`else
        grant_vid_c = iVidReq;
`endif
    end

    // State register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed five-cycle access sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (grant_c) state_d = S_STROBE;
            S_STROBE: state_d = S_WAIT1;
            S_WAIT1:  state_d = S_WAIT2;
            S_WAIT2:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered strobes, bus, data and acks
    always_comb begin
        owner_d     = owner_q;
        wr_d        = wr_q;
        sram_addr_d = sram_addr_q;
        sram_dout_d = sram_dout_q;
        cpu_data_d  = cpu_data_q;
        vid_data_d  = vid_data_q;
        sram_rd_d   = 1'b0;
        sram_wr_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        vid_ack_d   = 1'b0;
`ifdef SRAM_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_c) begin
                    if (grant_vid_c) begin
                        owner_d     = OWN_VID;
                        wr_d        = 1'b0;
                        sram_addr_d = iVidAddr;
                        sram_dout_d = '0;
                        sram_rd_d   = 1'b1;
                    end else begin
                        owner_d     = OWN_CPU;
                        wr_d        = iCpuWr;
                        sram_addr_d = iCpuAddr;
                        sram_dout_d = iCpuData;
                        sram_rd_d   = ~iCpuWr;
                        sram_wr_d   = iCpuWr;
                    end
`ifdef SRAM_ARB_RR_EN
                    last_d = grant_vid_c ? OWN_VID : OWN_CPU;
`endif
                end
            end
            S_WAIT2: begin
                // Read data is captured on the edge leaving WAIT2, alongside the ack
                if (owner_q == OWN_VID) begin
                    vid_ack_d = 1'b1;
                    if (!wr_q) vid_data_d = iSramDin;
                end else begin
                    cpu_ack_d = 1'b1;
                    if (!wr_q) cpu_data_d = iSramDin;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            owner_q     <= OWN_CPU;
            wr_q        <= 1'b0;
            sram_rd_q   <= 1'b0;
            sram_wr_q   <= 1'b0;
            sram_addr_q <= '0;
            sram_dout_q <= '0;
            cpu_data_q  <= '0;
            vid_data_q  <= '0;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_q      <= OWN_VID;
`endif
        end else begin
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            sram_rd_q   <= sram_rd_d;
            sram_wr_q   <= sram_wr_d;
            sram_addr_q <= sram_addr_d;
            sram_dout_q <= sram_dout_d;
            cpu_data_q  <= cpu_data_d;
            vid_data_q  <= vid_data_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_ack_q   <= vid_ack_d;
`ifdef SRAM_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign oCpuData  = cpu_data_q;
    assign oCpuAck   = cpu_ack_q;
    assign oVidData  = vid_data_q;
    assign oVidAck   = vid_ack_q;
    assign oSramRd   = sram_rd_q;
    assign oSramWr   = sram_wr_q;
    assign oSramAddr = sram_addr_q;
    assign oSramDout = sram_dout_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: self-checking bench for sram_arbiter. A transaction-level
// reference model predicts every output each cycle; a table of single accesses
// and a few hand-written sequences cover the corner cases; random traffic follows.
module tb_sram_arbiter;

    localparam int unsigned AW = 19;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_wr = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_data = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_rdata;
    logic          vid_ack;
    logic          sram_rd;
    logic          sram_wr;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dout;
    logic [DW-1:0] sram_din = '0;

    int checks = 0;
    int errors = 0;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .iClk(clk), .iRst(rst),
        .iCpuReq(cpu_req), .iCpuWr(cpu_wr), .iCpuAddr(cpu_addr), .iCpuData(cpu_data),
        .oCpuData(cpu_rdata), .oCpuAck(cpu_ack),
        .iVidReq(vid_req), .iVidAddr(vid_addr), .oVidData(vid_rdata), .oVidAck(vid_ack),
        .oSramRd(sram_rd), .oSramWr(sram_wr), .oSramAddr(sram_addr), .oSramDout(sram_dout),
        .iSramDin(sram_din)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (transaction level) ----------------
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] env_mem [int];

    bit            m_busy;
    int            m_t;          // cycles elapsed since the grant edge
    bit            m_vid;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_cpu_data;
    logic [DW-1:0] m_vid_data;
`ifdef SRAM_ARB_RR_EN
    bit            m_last_vid;
`endif

    function automatic logic [DW-1:0] def_val(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_t = 0; m_vid = 0; m_wr = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        m_cpu_data = '0; m_vid_data = '0;
`ifdef SRAM_ARB_RR_EN
        m_last_vid = 1;
`endif
    endtask

    // Advance the model across one rising edge using the inputs held at that edge
    task automatic model_step();
        bit win_vid;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_busy) begin
            m_t++;
            if (m_t == 4 && !m_wr) begin
                if (m_vid) m_vid_data = m_rdata;
                else       m_cpu_data = m_rdata;
            end
            if (m_t == 5) m_busy = 0;
        end else if (cpu_req || vid_req) begin
            win_vid = vid_req;
`ifdef SRAM_ARB_RR_EN
            if (cpu_req && vid_req) win_vid = !m_last_vid;
            m_last_vid = win_vid;
`endif
            m_busy = 1;
            m_t    = 1;
            m_vid  = win_vid;
            m_wr   = win_vid ? 1'b0 : cpu_wr;
            m_addr = win_vid ? vid_addr : cpu_addr;
            if (m_wr) begin
                m_wdata = cpu_data;
                ref_mem[int'(m_addr)] = cpu_data;
            end else begin
                m_rdata = ref_mem.exists(int'(m_addr)) ? ref_mem[int'(m_addr)] : def_val(m_addr);
            end
        end
    endtask

    task automatic compare_all();
        chk("sram_rd",  32'(sram_rd),  32'(m_busy && m_t == 1 && !m_wr));
        chk("sram_wr",  32'(sram_wr),  32'(m_busy && m_t == 1 && m_wr));
        chk("sram_addr", 32'(sram_addr), 32'(m_addr));
        if (m_busy && m_wr) chk("sram_dout", 32'(sram_dout), 32'(m_wdata));
        chk("cpu_ack",  32'(cpu_ack),  32'(m_busy && m_t == 4 && !m_vid));
        chk("vid_ack",  32'(vid_ack),  32'(m_busy && m_t == 4 && m_vid));
        chk("cpu_data", 32'(cpu_rdata), 32'(m_cpu_data));
        chk("vid_data", 32'(vid_rdata), 32'(m_vid_data));
    endtask

    // SRAM environment: commit writes, present read data for the current address
    task automatic env_sram();
        if (sram_wr) env_mem[int'(sram_addr)] = sram_dout;
        sram_din = env_mem.exists(int'(sram_addr)) ? env_mem[int'(sram_addr)] : def_val(sram_addr);
    endtask

    // One clock cycle: outputs sampled on the falling edge
    task automatic tick();
        @(negedge clk);
        model_step();
        compare_all();
        env_sram();
    endtask

    // Single access on one port; reports ack latency in cycles and returned data
    task automatic do_access(input bit is_vid, input bit wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, output int lat, output logic [DW-1:0] rdata);
        lat = -1;
        rdata = '0;
        if (is_vid) begin
            vid_req = 1'b1; vid_addr = addr;
        end else begin
            cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_data = wdata;
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (is_vid ? vid_ack : cpu_ack) begin
                lat = i;
                rdata = is_vid ? vid_rdata : cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        vid_req = 1'b0;
        tick();
    endtask

    task automatic reset_pulse();
        cpu_req = 1'b0; vid_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit            is_vid;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lat;
        int t_cpu;
        int t_vid;
        int acks;
        logic [DW-1:0] rd;
        logic [DW-1:0] exp_v [3];

        vecs[0] = '{is_vid: 0, wr: 1, addr: 19'h00123, wdata: 8'h5A, exp_data: 8'h00};
        vecs[1] = '{is_vid: 0, wr: 0, addr: 19'h00123, wdata: 8'h00, exp_data: 8'h5A};
        vecs[2] = '{is_vid: 1, wr: 0, addr: 19'h00123, wdata: 8'h00, exp_data: 8'h5A};
        vecs[3] = '{is_vid: 0, wr: 1, addr: 19'h7FFFF, wdata: 8'hC3, exp_data: 8'h5A};
        vecs[4] = '{is_vid: 0, wr: 0, addr: 19'h7FFFF, wdata: 8'h00, exp_data: 8'hC3};
        vecs[5] = '{is_vid: 1, wr: 0, addr: 19'h00000, wdata: 8'h00, exp_data: 8'hA5};

        model_reset();
        tick();
        tick();
        chk("reset_rd",   32'(sram_rd),   32'd0);
        chk("reset_addr", 32'(sram_addr), 32'd0);
        chk("reset_ack",  32'(cpu_ack | vid_ack), 32'd0);
        rst = 1'b0;
        tick();

        // Table of isolated accesses: fixed 4-cycle ack latency and returned data
        for (int v = 0; v < 6; v++) begin
            do_access(vecs[v].is_vid, vecs[v].wr, vecs[v].addr, vecs[v].wdata, lat, rd);
            chk($sformatf("vec%0d_lat", v), 32'(lat), 32'd4);
            chk($sformatf("vec%0d_data", v), 32'(rd), 32'(vecs[v].exp_data));
        end

        // Simultaneous CPU and video requests straight out of reset
        reset_pulse();
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 19'h00020;
        vid_req = 1'b1; vid_addr = 19'h00030;
        t_cpu = -1; t_vid = -1;
        for (int i = 1; i <= 20 && (cpu_req || vid_req); i++) begin
            tick();
            if (cpu_ack) begin t_cpu = i; cpu_req = 1'b0; end
            if (vid_ack) begin t_vid = i; vid_req = 1'b0; end
        end
        cpu_req = 1'b0; vid_req = 1'b0;
`ifdef SRAM_ARB_RR_EN
        chk("tie_cpu_lat", 32'(t_cpu), 32'd4);
        chk("tie_vid_lat", 32'(t_vid), 32'd9);
`else
        chk("tie_vid_lat", 32'(t_vid), 32'd4);
        chk("tie_cpu_lat", 32'(t_cpu), 32'd9);
`endif
        tick();

        // Video request held across three accesses: acks every five cycles
        exp_v[0] = 8'hB5; exp_v[1] = 8'hB4; exp_v[2] = 8'hB7;
        vid_req = 1'b1; vid_addr = 19'h00010;
        acks = 0;
        for (int i = 1; i <= 25 && acks < 3; i++) begin
            tick();
            if (vid_ack) begin
                chk($sformatf("burst%0d_time", acks), 32'(i), 32'(4 + 5 * acks));
                chk($sformatf("burst%0d_data", acks), 32'(vid_rdata), 32'(exp_v[acks]));
                acks++;
                vid_addr = vid_addr + AW'(1);
            end
        end
        chk("burst_count", 32'(acks), 32'd3);
        vid_req = 1'b0;
        tick();

        // Reset during WAIT1 of a CPU write: asynchronous clear, no ack afterwards
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 19'h00456; cpu_data = 8'h77;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("async_rd",   32'(sram_rd),   32'd0);
        chk("async_wr",   32'(sram_wr),   32'd0);
        chk("async_addr", 32'(sram_addr), 32'd0);
        chk("async_dout", 32'(sram_dout), 32'd0);
        chk("async_data", 32'(cpu_rdata | vid_rdata), 32'd0);
        cpu_req = 1'b0;
        tick();
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cpu_ack || vid_ack) acks++;
        end
        chk("reset_no_ack", 32'(acks), 32'd0);
        do_access(1'b0, 1'b0, 19'h00456, 8'h00, lat, rd);
        chk("post_reset_lat",  32'(lat), 32'd4);
        chk("post_reset_data", 32'(rd),  32'h77);

        // CPU drops its request in WAIT1; access still completes, no grant in DONE
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 19'h00123;
        tick();
        tick();
        cpu_req = 1'b0;
        lat = -1;
        for (int i = 3; i <= 10; i++) begin
            tick();
            if (cpu_ack) begin lat = i; break; end
        end
        chk("drop_lat",  32'(lat), 32'd4);
        chk("drop_data", 32'(cpu_rdata), 32'h5A);
        vid_req = 1'b1; vid_addr = 19'h00040;
        tick();
        chk("done_no_grant", 32'(sram_rd), 32'd0);
        tick();
        chk("idle_grant", 32'(sram_rd), 32'd1);
        for (int i = 0; i < 6 && vid_req; i++) begin
            tick();
            if (vid_ack) vid_req = 1'b0;
        end
        vid_req = 1'b0;
        tick();

        // Random traffic on a small address window, checked by the model each cycle
        for (int c = 0; c < 600; c++) begin
            if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req  = 1'b1;
                cpu_wr   = 1'($urandom_range(0, 1));
                cpu_addr = AW'($urandom_range(0, 7));
                cpu_data = DW'($urandom);
            end
            if (!vid_req && $urandom_range(0, 2) == 0) begin
                vid_req  = 1'b1;
                vid_addr = AW'($urandom_range(0, 7));
            end
            if (cpu_req && $urandom_range(0, 19) == 0) cpu_req = 1'b0;
            tick();
            chk("ack_exclusive", 32'(cpu_ack & vid_ack), 32'd0);
            chk("strobe_exclusive", 32'(sram_rd & sram_wr), 32'd0);
            if (cpu_ack) cpu_req = 1'b0;
            if (vid_ack) vid_req = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
